// File: rtl/pbus_regs_pkg.sv
// pbus_regs_pkg: register map, bit positions and sizes shared by the pbus register block
package pbus_regs_pkg;
  localparam int DW = 16;
  localparam int TW = 8;
  localparam int FIFO_DEPTH = 4;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam logic [2:0] ADDR_CTRL = 3'd0;
  localparam logic [2:0] ADDR_STATUS = 3'd1;
  localparam logic [2:0] ADDR_COUNT = 3'd2;
  localparam logic [2:0] ADDR_COMPARE = 3'd3;
  localparam logic [2:0] ADDR_TXDATA = 3'd4;
  localparam logic [2:0] ADDR_SCRATCH = 3'd5;
  localparam int CTRL_CNTEN = 0;
  localparam int CTRL_IRQEN = 1;
  localparam int CTRL_AUTOCLR = 2;
  localparam int ST_MATCH = 0;
  localparam int ST_EMPTY = 1;
  localparam int ST_FULL = 2;
  localparam int ST_LEVEL = 3;
  localparam int ST_OVF = 6;
  function automatic logic [DW-1:0] status_word(input logic match, input logic empty, input logic full,
                                                input logic [LW-1:0] level, input logic ovf);
    return {9'b0, ovf, level, full, empty, match};
  endfunction
endpackage

// File: rtl/pbus_txfifo.sv
// pbus_txfifo: 4-deep show-ahead byte FIFO; pop of an empty FIFO is ignored, push when full only with a pop
module pbus_txfifo
  import pbus_regs_pkg::*;
(
  input  logic          Clk,
  input  logic          Reset,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [TW-1:0] i_data,
  output logic [TW-1:0] o_data,
  output logic [LW-1:0] o_level,
  output logic          o_full,
  output logic          o_empty
);
  logic [TW-1:0] r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;
  logic          w_push;
  logic          w_pop;
  assign o_level = r_level;
  assign o_empty = r_level == '0;
  assign o_full  = r_level == LW'(FIFO_DEPTH);
  assign w_pop   = i_pop & ~o_empty;
  assign w_push  = i_push & (~o_full | w_pop);
  assign o_data  = o_empty ? '0 : r_mem[r_rd_ptr];
  // storage has no reset: contents are meaningless once the pointers are cleared
  always_ff @(posedge Clk)
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  // pointers wrap naturally at the FIFO depth; level tracks occupancy
  always_ff @(posedge Clk)
    if (Reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
      r_level <= r_level + LW'(w_push) - LW'(w_pop);
    end
endmodule

// File: rtl/pbus_regs.sv
// pbus_regs: CPU register block with free-running compare counter, interrupt and TX byte FIFO
module pbus_regs
  import pbus_regs_pkg::*;
(
  input  logic          Clk,
  input  logic          Reset,
  input  logic          RD,
  input  logic          WR,
  input  logic [2:0]    Addr,
  input  logic [DW-1:0] WData,
  output logic [DW-1:0] RData,
  output logic          RValid,
  output logic [TW-1:0] TxData,
  output logic          TxValid,
  input  logic          TxReady,
  output logic          Irq
);
  logic [2:0]    r_ctrl;
  logic [DW-1:0] r_count;
  logic [DW-1:0] r_compare;
  logic [DW-1:0] r_scratch;
  logic          r_match;
  logic          r_ovf;
  logic [DW-1:0] r_rdata;
  logic          r_rvalid;
  logic          w_wr_ctrl;
  logic          w_wr_status;
  logic          w_wr_count;
  logic          w_wr_compare;
  logic          w_wr_scratch;
  logic          w_push;
  logic          w_pop;
  logic          w_hit;
  logic          w_ovf;
  logic          w_full;
  logic          w_empty;
  logic [LW-1:0] w_level;
  logic [DW-1:0] w_status;
  logic [DW-1:0] w_rdata;
  assign w_wr_ctrl    = WR & (Addr == ADDR_CTRL);
  assign w_wr_status  = WR & (Addr == ADDR_STATUS);
  assign w_wr_count   = WR & (Addr == ADDR_COUNT);
  assign w_wr_compare = WR & (Addr == ADDR_COMPARE);
  assign w_wr_scratch = WR & (Addr == ADDR_SCRATCH);
  assign w_push       = WR & (Addr == ADDR_TXDATA);
  assign w_pop        = TxValid & TxReady;
  assign w_hit        = r_ctrl[CTRL_CNTEN] & (r_count == r_compare);
  assign w_ovf        = w_push & w_full & ~w_pop;
  assign TxValid      = ~w_empty;
  assign Irq          = r_match & r_ctrl[CTRL_IRQEN];
  assign RData        = r_rdata;
  assign RValid       = r_rvalid;
  assign w_status     = status_word(r_match, w_empty, w_full, w_level, r_ovf);
  assign w_rdata = (Addr == ADDR_CTRL)    ? DW'(r_ctrl) :
                   (Addr == ADDR_STATUS)  ? w_status :
                   (Addr == ADDR_COUNT)   ? r_count :
                   (Addr == ADDR_COMPARE) ? r_compare :
                   (Addr == ADDR_SCRATCH) ? r_scratch : '0;
  pbus_txfifo u_txfifo (
    .Clk     (Clk),
    .Reset   (Reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (WData[TW-1:0]),
    .o_data  (TxData),
    .o_level (w_level),
    .o_full  (w_full),
    .o_empty (w_empty)
  );
  // control registers; CPU write to COUNT beats increment/autoclear, new match/overflow beats W1C
  always_ff @(posedge Clk)
    if (Reset) begin
      r_ctrl    <= '0;
      r_count   <= '0;
      r_compare <= '0;
      r_scratch <= '0;
      r_match   <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      if (w_wr_ctrl) r_ctrl <= WData[2:0];
      if (w_wr_compare) r_compare <= WData;
      if (w_wr_scratch) r_scratch <= WData;
      r_count <= w_wr_count ? WData :
                 ~r_ctrl[CTRL_CNTEN] ? r_count :
                 (w_hit & r_ctrl[CTRL_AUTOCLR]) ? '0 : r_count + DW'(1);
      r_match <= w_hit | (r_match & ~(w_wr_status & WData[ST_MATCH]));
      r_ovf   <= w_ovf | (r_ovf & ~(w_wr_status & WData[ST_OVF]));
    end
  // read data is captured from pre-write register values; RData holds between reads
  always_ff @(posedge Clk)
    if (Reset) begin
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
    end else begin
      r_rvalid <= RD;
      if (RD) r_rdata <= w_rdata;
    end
endmodule

// File: tb/tb_pbus_regs.sv
// tb_pbus_regs: scenario-per-task bench with a queue of expected read/stream values
module tb_pbus_regs;
  import pbus_regs_pkg::*;
  logic        Clk = 1'b0;
  logic        Reset;
  logic        RD;
  logic        WR;
  logic [2:0]  Addr;
  logic [15:0] WData;
  logic [15:0] RData;
  logic        RValid;
  logic [7:0]  TxData;
  logic        TxValid;
  logic        TxReady;
  logic        Irq;
  int          errors = 0;
  int          checks = 0;
  logic [15:0] sb[$];
  logic [15:0] exp_v;
  logic [15:0] got;
  logic        gv;

  always #5 Clk = ~Clk;

  pbus_regs dut (
    .Clk(Clk), .Reset(Reset), .RD(RD), .WR(WR), .Addr(Addr), .WData(WData),
    .RData(RData), .RValid(RValid), .TxData(TxData), .TxValid(TxValid),
    .TxReady(TxReady), .Irq(Irq)
  );

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    WR = 1'b1; Addr = a; WData = d;
    @(negedge Clk);
    WR = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [15:0] d, output logic v);
    RD = 1'b1; Addr = a;
    @(negedge Clk);
    RD = 1'b0;
    d = RData; v = RValid;
  endtask

  task automatic test_reset;
    Reset = 1'b1; RD = 1'b0; WR = 1'b0; Addr = '0; WData = '0; TxReady = 1'b0;
    repeat (2) @(negedge Clk);
    checks++; if (RValid !== 1'b0 || RData !== 16'h0000) begin errors++; $display("FAIL reset_rd: v=%b d=%h want v=0 d=0000", RValid, RData); end
    checks++; if (TxValid !== 1'b0 || TxData !== 8'h00) begin errors++; $display("FAIL reset_tx: v=%b d=%h want v=0 d=00", TxValid, TxData); end
    checks++; if (Irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b want 0", Irq); end
    Reset = 1'b0;
    sb.push_back(16'h0002);
    rd(ADDR_STATUS, got, gv); exp_v = sb.pop_front();
    checks++; if (gv !== 1'b1 || got !== exp_v) begin errors++; $display("FAIL reset_status: v=%b d=%h want v=1 d=%h", gv, got, exp_v); end
  endtask

  task automatic test_scratch;
    wr(ADDR_SCRATCH, 16'hBEEF);
    sb.push_back(16'hBEEF);
    rd(ADDR_SCRATCH, got, gv); exp_v = sb.pop_front();
    checks++; if (gv !== 1'b1 || got !== exp_v) begin errors++; $display("FAIL scratch_rd: v=%b d=%h want v=1 d=%h", gv, got, exp_v); end
    @(negedge Clk);
    checks++; if (RValid !== 1'b0 || RData !== 16'hBEEF) begin errors++; $display("FAIL rdata_hold: v=%b d=%h want v=0 d=beef", RValid, RData); end
    sb.push_back(16'h0000);
    rd(3'd7, got, gv); exp_v = sb.pop_front();
    checks++; if (gv !== 1'b1 || got !== exp_v) begin errors++; $display("FAIL unmapped_rd: v=%b d=%h want v=1 d=%h", gv, got, exp_v); end
    sb.push_back(16'h0000);
    rd(ADDR_TXDATA, got, gv); exp_v = sb.pop_front();
    checks++; if (got !== exp_v) begin errors++; $display("FAIL txdata_rd: d=%h want %h", got, exp_v); end
    wr(ADDR_CTRL, 16'hFFF8);
    sb.push_back(16'h0000);
    rd(ADDR_CTRL, got, gv); exp_v = sb.pop_front();
    checks++; if (got !== exp_v) begin errors++; $display("FAIL ctrl_unused: d=%h want %h", got, exp_v); end
    sb.push_back(16'hBEEF);
    RD = 1'b1; WR = 1'b1; Addr = ADDR_SCRATCH; WData = 16'h1111;
    @(negedge Clk);
    RD = 1'b0; WR = 1'b0; exp_v = sb.pop_front();
    checks++; if (RValid !== 1'b1 || RData !== exp_v) begin errors++; $display("FAIL rdwr_prewrite: v=%b d=%h want v=1 d=%h", RValid, RData, exp_v); end
    sb.push_back(16'h1111);
    rd(ADDR_SCRATCH, got, gv); exp_v = sb.pop_front();
    checks++; if (got !== exp_v) begin errors++; $display("FAIL rdwr_written: d=%h want %h", got, exp_v); end
  endtask

  task automatic test_match;
    wr(ADDR_COMPARE, 16'd5);
    wr(ADDR_COUNT, 16'd0);
    wr(ADDR_CTRL, 16'h0007);
    for (int i = 1; i <= 6; i++) begin
      @(negedge Clk);
      checks++; if (Irq !== (i == 6)) begin errors++; $display("FAIL match_irq cyc%0d: got %b want %b", i, Irq, i == 6); end
    end
    sb.push_back(16'h0000);
    rd(ADDR_COUNT, got, gv); exp_v = sb.pop_front();
    checks++; if (got !== exp_v) begin errors++; $display("FAIL autoclr_count: d=%h want %h", got, exp_v); end
    sb.push_back(16'h0003);
    rd(ADDR_STATUS, got, gv); exp_v = sb.pop_front();
    checks++; if (got !== exp_v) begin errors++; $display("FAIL match_status: d=%h want %h", got, exp_v); end
    wr(ADDR_STATUS, 16'h0001);
    checks++; if (Irq !== 1'b0) begin errors++; $display("FAIL w1c_irq: got %b want 0", Irq); end
    wr(ADDR_CTRL, 16'h0000);
  endtask

  task automatic test_fifo_ovf;
    TxReady = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      wr(ADDR_TXDATA, 16'(i * 8'h11));
      if (i <= 4) sb.push_back(16'(i * 8'h11));
    end
    checks++; if (TxValid !== 1'b1 || TxData !== 8'h11) begin errors++; $display("FAIL full_head: v=%b d=%h want v=1 d=11", TxValid, TxData); end
    sb.push_back(16'h0064);
    rd(ADDR_STATUS, got, gv); exp_v = sb.pop_back();
    checks++; if (got !== exp_v) begin errors++; $display("FAIL full_status: d=%h want %h", got, exp_v); end
    TxReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_v = sb.pop_front();
      checks++; if (TxValid !== 1'b1 || TxData !== exp_v[7:0]) begin errors++; $display("FAIL drain%0d: v=%b d=%h want v=1 d=%h", i, TxValid, TxData, exp_v[7:0]); end
      @(negedge Clk);
    end
    checks++; if (TxValid !== 1'b0) begin errors++; $display("FAIL drain_empty: v=%b want 0", TxValid); end
    TxReady = 1'b0;
    wr(ADDR_STATUS, 16'h0040);
    sb.push_back(16'h0002);
    rd(ADDR_STATUS, got, gv); exp_v = sb.pop_front();
    checks++; if (got !== exp_v) begin errors++; $display("FAIL ovf_clear: d=%h want %h", got, exp_v); end
  endtask

  task automatic test_full_push_pop;
    TxReady = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      wr(ADDR_TXDATA, 16'(8'hA0 + i));
      if (i >= 2) sb.push_back(16'(8'hA0 + i));
    end
    TxReady = 1'b1;
    sb.push_back(16'h00A5);
    wr(ADDR_TXDATA, 16'h00A5);
    TxReady = 1'b0;
    checks++; if (TxData !== 8'hA2) begin errors++; $display("FAIL fullpp_head: d=%h want a2", TxData); end
    rd(ADDR_STATUS, got, gv);
    checks++; if (got !== 16'h0024) begin errors++; $display("FAIL fullpp_status: d=%h want 0024", got); end
    TxReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_v = sb.pop_front();
      checks++; if (TxValid !== 1'b1 || TxData !== exp_v[7:0]) begin errors++; $display("FAIL fullpp_drain%0d: v=%b d=%h want v=1 d=%h", i, TxValid, TxData, exp_v[7:0]); end
      @(negedge Clk);
    end
    checks++; if (TxValid !== 1'b0) begin errors++; $display("FAIL fullpp_empty: v=%b want 0", TxValid); end
    TxReady = 1'b0;
  endtask

  task automatic test_wrap_reset;
    wr(ADDR_COMPARE, 16'h1234);
    wr(ADDR_COUNT, 16'hFFFF);
    wr(ADDR_CTRL, 16'h0001);
    sb.push_back(16'hFFFF);
    sb.push_back(16'h0000);
    rd(ADDR_COUNT, got, gv); exp_v = sb.pop_front();
    checks++; if (got !== exp_v) begin errors++; $display("FAIL wrap_pre: d=%h want %h", got, exp_v); end
    rd(ADDR_COUNT, got, gv); exp_v = sb.pop_front();
    checks++; if (got !== exp_v) begin errors++; $display("FAIL wrap_post: d=%h want %h", got, exp_v); end
    wr(ADDR_CTRL, 16'h0000);
    wr(ADDR_COUNT, 16'h0000);
    wr(ADDR_COMPARE, 16'h0000);
    wr(ADDR_CTRL, 16'h0003);
    @(negedge Clk);
    checks++; if (Irq !== 1'b1) begin errors++; $display("FAIL pre_reset_irq: got %b want 1", Irq); end
    wr(ADDR_TXDATA, 16'h0077);
    rd(ADDR_SCRATCH, got, gv);
    Reset = 1'b1; TxReady = 1'b1; RD = 1'b1; Addr = ADDR_SCRATCH;
    @(negedge Clk);
    checks++; if (RValid !== 1'b0 || RData !== 16'h0000) begin errors++; $display("FAIL midreset_rd: v=%b d=%h want v=0 d=0000", RValid, RData); end
    checks++; if (TxValid !== 1'b0 || TxData !== 8'h00 || Irq !== 1'b0) begin errors++; $display("FAIL midreset_out: txv=%b txd=%h irq=%b want 0 00 0", TxValid, TxData, Irq); end
    Reset = 1'b0; TxReady = 1'b0; RD = 1'b0;
    sb.push_back(16'h0000);
    rd(ADDR_COUNT, got, gv); exp_v = sb.pop_front();
    checks++; if (got !== exp_v) begin errors++; $display("FAIL midreset_count: d=%h want %h", got, exp_v); end
    sb.push_back(16'h0002);
    rd(ADDR_STATUS, got, gv); exp_v = sb.pop_front();
    checks++; if (got !== exp_v) begin errors++; $display("FAIL midreset_status: d=%h want %h", got, exp_v); end
  endtask

  initial begin
    test_reset;
    test_scratch;
    test_match;
    test_fifo_ovf;
    test_full_push_pop;
    test_wrap_reset;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
